// File: rtl/kf_pkg.sv
// Shared types and constants for the Kalman filter measurement path.
package kf_pkg;

  localparam int unsigned KF_MEASURE_DIM = 6;
  localparam int unsigned KF_DWIDTH      = 64;

  // Biased exponent of an IEEE-754 double that encodes NaN or infinity
  localparam logic [10:0] FP64_EXP_ALL_ONES = 11'h7FF;

  typedef logic [KF_MEASURE_DIM-1:0][KF_DWIDTH-1:0] meas_vec_t;

  typedef enum logic [0:0] {
    FILL,
    DISCARD
  } ingest_state_t;

endpackage

// File: rtl/kf_meas_pingpong.sv
// Two-bank measurement buffer: one bank is filled while the other is presented to the core.
module kf_meas_pingpong
  import kf_pkg::*;
#(
  parameter int unsigned MEASURE_DIM = KF_MEASURE_DIM,
  parameter int unsigned DWIDTH      = KF_DWIDTH
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  wr_en_i,
  input  logic [$clog2(MEASURE_DIM)-1:0]        wr_idx_i,
  input  logic [DWIDTH-1:0]                     wr_data_i,
  input  logic                                  commit_i,
  input  logic                                  ack_i,
  output logic                                  wr_full_o,
  output logic                                  rd_valid_o,
  output logic [MEASURE_DIM-1:0][DWIDTH-1:0]    rd_data_o
);

  logic [DWIDTH-1:0] bank_q [2][MEASURE_DIM];
  logic [1:0]        full_q;
  logic              wr_sel_q;
  logic              rd_sel_q;
  logic              do_ack;

  // Commit only targets an empty bank and ack only a full one, so the two never collide
  assign do_ack     = ack_i && full_q[rd_sel_q];
  assign wr_full_o  = full_q[wr_sel_q];
  assign rd_valid_o = full_q[rd_sel_q];

  always_comb begin
    for (int unsigned i = 0; i < MEASURE_DIM; i++) begin
      rd_data_o[i] = bank_q[rd_sel_q][i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < MEASURE_DIM; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else begin
      if (wr_en_i) begin
        bank_q[wr_sel_q][wr_idx_i] <= wr_data_i;
      end
      if (commit_i) begin
        full_q[wr_sel_q] <= 1'b1;
        wr_sel_q         <= !wr_sel_q;
      end
      if (do_ack) begin
        full_q[rd_sel_q] <= 1'b0;
        rd_sel_q         <= !rd_sel_q;
      end
    end
  end

endmodule

// File: rtl/kf_measurement_ingest.sv
// Serial measurement ingest: frames components into a ping-pong buffer for the Kalman core.
// Optional non-finite frame dropping is enabled by defining MDI_NONFINITE_CHECK_EN.
module kf_measurement_ingest
  import kf_pkg::*;
#(
  parameter int unsigned MEASURE_DIM = KF_MEASURE_DIM,
  parameter int unsigned DWIDTH      = KF_DWIDTH,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [DWIDTH-1:0]                  s_data,
  input  logic                               s_last,
  output logic [MEASURE_DIM-1:0][DWIDTH-1:0] Z_k,
  output logic                               mdi_valid,
  input  logic                               mdi_ack,
  output logic                               frame_err,
  output logic [CNT_W-1:0]                   err_count,
  output logic [CNT_W-1:0]                   drop_count
);

  localparam int unsigned      IDX_W    = $clog2(MEASURE_DIM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEASURE_DIM - 1);

  ingest_state_t    state_q;
  logic [IDX_W-1:0] idx_q;
  logic             frame_err_q;
  logic [CNT_W-1:0] err_count_q;

  logic wr_full;
  logic accept;
  logic fill_beat;
  logic at_last;
  logic frame_end;
  logic frame_bad;
  logic commit;
  logic short_err;
  logic long_err;

  // DISCARD drains the rest of a long frame even when both banks are full
  assign s_ready   = !rst && (state_q == DISCARD || !wr_full);
  assign accept    = s_valid && s_ready;
  assign fill_beat = accept && (state_q == FILL);
  assign at_last   = (idx_q == LAST_IDX);
  assign frame_end = fill_beat && s_last && at_last;
  assign commit    = frame_end && !frame_bad;
  assign short_err = fill_beat && s_last && !at_last;
  assign long_err  = fill_beat && !s_last && at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      frame_err_q <= short_err || long_err;
      if ((short_err || long_err) && err_count_q != '1) begin
        err_count_q <= err_count_q + CNT_W'(1);
      end
      case (state_q)
        FILL: begin
          if (fill_beat) begin
            idx_q <= (s_last || at_last) ? '0 : idx_q + IDX_W'(1);
            if (long_err) begin
              state_q <= DISCARD;
            end
          end
        end
        DISCARD: begin
          if (accept && s_last) begin
            idx_q   <= '0;
            state_q <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign frame_err = frame_err_q;
  assign err_count = err_count_q;

`ifdef MDI_NONFINITE_CHECK_EN
  logic             bad_q;
  logic             beat_bad;
  logic [CNT_W-1:0] drop_count_q;

  assign beat_bad  = (s_data[62:52] == FP64_EXP_ALL_ONES);
  assign frame_bad = bad_q || beat_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      bad_q        <= 1'b0;
      drop_count_q <= '0;
    end else begin
      if (fill_beat) begin
        bad_q <= (s_last || at_last) ? 1'b0 : frame_bad;
      end
      if (frame_end && frame_bad && drop_count_q != '1) begin
        drop_count_q <= drop_count_q + CNT_W'(1);
      end
    end
  end

  assign drop_count = drop_count_q;
`else
  assign frame_bad  = 1'b0;
  assign drop_count = '0;
`endif

  kf_meas_pingpong #(
    .MEASURE_DIM(MEASURE_DIM),
    .DWIDTH     (DWIDTH)
  ) u_pingpong (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (fill_beat),
    .wr_idx_i  (idx_q),
    .wr_data_i (s_data),
    .commit_i  (commit),
    .ack_i     (mdi_ack),
    .wr_full_o (wr_full),
    .rd_valid_o(mdi_valid),
    .rd_data_o (Z_k)
  );

endmodule
